// File: rtl/debug_slave_sysclk_bridge_pkg.sv
// Shared types for the debug-slave sysclk bridge: arm FSM states, default widths
// and the default-width command record.
package debug_slave_pkg;

    localparam int DEF_SR_W = 38;
    localparam int DEF_IR_W = 2;

    typedef enum logic {
        ARMING = 1'b0,
        RUN    = 1'b1
    } arm_state_t;

    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/debug_slave_sysclk_bridge_if.sv
// Command stream from the bridge (master) to the OCI consumer (slave).
interface debug_slave_sysclk_bridge_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2
);
    localparam int NUM_CH = 2 ** IR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   cmd_data;
    logic [NUM_CH-1:0] cmd_action;
    logic              cmd_no_action;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, cmd_action, cmd_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, cmd_action, cmd_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/debug_slave_cmd_fifo.sv
// Single-clock command FIFO; head is forced to zero while empty so the
// consumer never sees stale entries.
module debug_slave_cmd_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_reg;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= din;
    end
endmodule

// File: rtl/debug_slave_sysclk_bridge.sv
// Synchronises tck-domain update strobes into clk and queues each DR update as a
// command. Optional counters: define DEBUG_SLAVE_BRIDGE_STATS_EN.
module debug_slave_sysclk_bridge
    import debug_slave_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            vs_uir,
    input  logic            vs_udr,
    output logic [SR_W-1:0] jdo,
    output logic            overflow,
    input  logic            clr_overflow,
`ifdef DEBUG_SLAVE_BRIDGE_STATS_EN
    output logic [15:0]     stat_accepted,
    output logic [15:0]     stat_dropped,
`endif
    debug_slave_sysclk_bridge_if.master cmd
);
    localparam int NUM_CH = 2 ** IR_W;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    arm_state_t             state_reg;
    logic [2:0]             arm_cnt_reg;
    logic [SYNC_STAGES-1:0] uir_sync_reg;
    logic [SYNC_STAGES-1:0] udr_sync_reg;
    logic                   uir_prev_reg;
    logic                   udr_prev_reg;
    logic                   uir_edge_reg;
    logic                   udr_edge_reg;
    logic [IR_W-1:0]        ir_q_reg;

    logic [IR_W+SR_W-1:0]   fifo_head;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = cmd.cmd_valid && cmd.cmd_ready;
    assign push_ok   = udr_edge_reg && (!fifo_full || pop);
    assign drop      = udr_edge_reg && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ARMING;
            arm_cnt_reg  <= '0;
            uir_sync_reg <= '0;
            udr_sync_reg <= '0;
            uir_prev_reg <= 1'b0;
            udr_prev_reg <= 1'b0;
            uir_edge_reg <= 1'b0;
            udr_edge_reg <= 1'b0;
            ir_q_reg     <= '0;
            jdo          <= '0;
            overflow     <= 1'b0;
        end else begin
            uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], vs_uir};
            udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], vs_udr};
            uir_prev_reg <= uir_sync_reg[SYNC_STAGES-1];
            udr_prev_reg <= udr_sync_reg[SYNC_STAGES-1];
            case (state_reg)
                // prev keeps tracking while armed so a level high at reset release is not an edge.
                ARMING: begin
                    uir_edge_reg <= 1'b0;
                    udr_edge_reg <= 1'b0;
                    if (arm_cnt_reg == 3'(SYNC_STAGES)) state_reg <= RUN;
                    else arm_cnt_reg <= arm_cnt_reg + 3'd1;
                end
                default: begin
                    uir_edge_reg <= uir_sync_reg[SYNC_STAGES-1] && !uir_prev_reg;
                    udr_edge_reg <= udr_sync_reg[SYNC_STAGES-1] && !udr_prev_reg;
                end
            endcase
            if (uir_edge_reg) ir_q_reg <= ir_in;
            if (udr_edge_reg) jdo <= sr;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    debug_slave_cmd_fifo #(
        .W     (IR_W + SR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .din   ({ir_q_reg, sr}),
        .head  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd.cmd_valid     = !fifo_empty;
    assign cmd.cmd_ir        = fifo_head[IR_W+SR_W-1:SR_W];
    assign cmd.cmd_data      = fifo_head[SR_W-1:0];
    assign cmd.cmd_no_action = cmd.cmd_valid && !cmd.cmd_data[SR_W-1];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_action
            assign cmd.cmd_action[gi] = cmd.cmd_valid && cmd.cmd_data[SR_W-1]
                                        && (cmd.cmd_ir == IR_W'(gi));
        end
    endgenerate

`ifdef DEBUG_SLAVE_BRIDGE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_accepted <= '0;
            stat_dropped  <= '0;
        end else begin
            if (push_ok && stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 16'd1;
            if (drop) begin
                if (stat_dropped != 16'hFFFF) stat_dropped <= stat_dropped + 16'd1;
            end else if (clr_overflow) begin
                stat_dropped <= '0;
            end
        end
    end
`endif
endmodule
